acia_rx_ctrl: RTL
=================

# acia_rx_ctrl

Receive-side controller for the ACIA serial receiver. It generates the peripheral clock-enable that paces the receiver and captures the receiver's byte and error strobes into a small FIFO. It presents a two-register CPU bus interface (status/control and data) and raises a level interrupt to the 6502 core. It sits between the receive submodule and the system bus decode.

## Interface
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..16
- PCLK_DIV, 4, clk cycles per pclk enable pulse; 1..256
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- cs  in  1  register access select, one clk cycle per access
- we  in  1  1 = write, 0 = read
- rs  in  1  register select: 0 = status/control, 1 = data
- din  in  8  write data
- dout  out  8  read data, combinational from rs and current state
- irq  out  1  interrupt request, registered, active-high level
- pclk  out  1  peripheral clock-enable to receiver
- rx_dat  in  8  received byte from receiver
- rx_stb  in  1  byte-valid from receiver; held high for one or more pclk periods
- rx_err  in  1  framing-error level from receiver

## Operation
- Prescaler: counter runs 0..PCLK_DIV-1 and wraps; pclk=1 only when counter==PCLK_DIV-1. With PCLK_DIV=1, pclk is constant 1 out of reset.
- Edge capture: rx_stb and rx_err are registered each clk. A rising edge (prev=0, now=1) of rx_stb is a push event using the current rx_dat. A rising edge of rx_err sets FE.
- FIFO: circular buffer with rd_ptr and wr_ptr of width log2(FIFO_DEPTH), which wrap naturally. count has width log2(FIFO_DEPTH)+1 and ranges 0..FIFO_DEPTH.
- Push when count<FIFO_DEPTH: write the entry, wr_ptr+1, count+1.
- Push when full: drop the byte and set OVR. Exception: if a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Push and pop in the same cycle with count in 1..FIFO_DEPTH-1: both happen and count is unchanged.
- Pop: cs & ~we & rs=1 with count>0 gives rd_ptr+1 and count-1. A data read when empty returns 8'h00 and leaves the pointers unchanged.
- Status read (rs=0): {IRQ, 3'b000, FULL, OVR, FE, RDRF}.
  - RDRF = count>0.
  - FULL = count==FIFO_DEPTH.
  - IRQ = current irq output.
- FE and OVR clear at the end of a status read cycle. If a set event occurs in the same cycle as the clear, the set wins and the flag stays 1.
- Control write (rs=0, we=1):
  - bit0 RIE, receive interrupt enable.
  - bit1 FLUSH, self-clearing: empties the FIFO and clears FE and OVR.
  - bit2 EIE, error interrupt enable.
  - bits[7:4] THRESH. THRESH=0 is treated as 1; THRESH>FIFO_DEPTH is treated as FIFO_DEPTH.
- FLUSH coinciding with a push: FLUSH wins and the byte is dropped. FLUSH coinciding with a flag set: FLUSH wins.
- Data-register writes (rs=1, we=1) are ignored.
- Control readback is not provided.

## Timing
- Reset values:
  - Outputs: dout reflects the reset state (status read = 8'h00), irq=0, pclk=0 (1 if PCLK_DIV=1).
  - Internal state: prescaler 0, FIFO empty, FE=OVR=0, RIE=EIE=0, THRESH=1, edge registers 0.
- Reset mid-operation discards all FIFO contents and flags on the next clk edge.
- Push latency: rx_stb rising at clk edge N is registered at N, detected at N+1, and RDRF reads 1 from cycle N+1 onward.
- irq <= (RIE & count>=THRESH_eff) | (EIE & (FE|OVR)), one cycle after the state that causes it.
- irq deasserts one cycle after the pop or flag clear that removes the cause.
- Reads are combinational: dout shows the head entry during the cycle; the pop takes effect at the closing clk edge.
- The pclk period is exactly PCLK_DIV clk cycles, uninterrupted by bus activity.

## Test plan
- Reset, PCLK_DIV=4: pclk pulses on cycles 3,7,11,… after reset release; status reads 8'h00; irq=0.
- Push 8'h55 then 8'hAA via rx_stb pulses held 4 cycles each: status bit0=1. Data reads return 55, then AA, then 00, and bit0 drops after the second read.
- Push 17 bytes into a depth-16 FIFO without reads: FULL=1, OVR=1. Reads return the first 16 bytes in order. A status read clears OVR.
- Write control 8'h31 (RIE, THRESH=3): irq stays 0 after 2 pushes and rises one cycle after the 3rd detected push. One data read drops irq the following cycle.
- rx_err rising with EIE=1: FE=1 and irq=1. A status read clears FE. A second rx_err edge in the same cycle as the status read leaves FE=1.
- Full FIFO with push and pop in the same cycle: count stays 16, OVR stays 0, and the new byte is read last. FLUSH in the same cycle as a push leaves the FIFO empty.

Source files
------------

// File: rtl/acia_rx_ctrl.sv
// acia_rx_ctrl: ACIA receive controller - pclk prescaler, strobe edge capture,
// receive FIFO, status/control + data registers and level interrupt.
// Ports:
//   clk, reset_n       system clock, synchronous active-low reset
//   cs, we, rs, din    bus access (rs 0 = status/control, 1 = data)
//   dout               combinational read data
//   irq                registered interrupt request
//   pclk               clock-enable pulse to the receiver
//   rx_dat/stb/err     receiver byte, byte-valid level, framing-error level
module acia_rx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int PCLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       pclk,
  input  logic [7:0] rx_dat,
  input  logic       rx_stb,
  input  logic       rx_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = PCLK_DIV > 1 ? $clog2(PCLK_DIV) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  logic [PW-1:0] div_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          stb_q, stb_p, err_q, err_p;
  logic          fe, ovr, rie, eie;
  logic [4:0]    thresh, thr_in, thr_eff;
  logic          push_ev, err_ev, pop, flush, stat_rd, ctl_wr, full, rdrf, accept;
  logic          unused;
  assign unused = din[3];
  assign pclk = div_cnt == PW'(PCLK_DIV - 1);
  always_ff @(posedge clk)
    if (!reset_n) div_cnt <= '0;
    else div_cnt <= pclk ? '0 : div_cnt + PW'(1);
  // Edges are taken between the two capture stages so the strobes are fully registered.
  assign push_ev = stb_q & ~stb_p;
  assign err_ev  = err_q & ~err_p;
  assign full    = count == DEPTH;
  assign rdrf    = count != '0;
  assign pop     = cs & ~we & rs & rdrf;
  assign stat_rd = cs & ~we & ~rs;
  assign ctl_wr  = cs & we & ~rs;
  assign flush   = ctl_wr & din[1];
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign accept  = push_ev & (~full | pop) & ~flush;
  assign thr_in  = {1'b0, din[7:4]};
  assign thr_eff = thr_in == 5'd0 ? 5'd1 : thr_in > 5'(FIFO_DEPTH) ? 5'(FIFO_DEPTH) : thr_in;
  assign dout    = rs ? (rdrf ? mem[rd_ptr] : 8'h00) : {irq, 3'b000, full, ovr, fe, rdrf};
  always_ff @(posedge clk)
    if (reset_n && accept) mem[wr_ptr] <= rx_dat;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stb_q  <= 1'b0;
      stb_p  <= 1'b0;
      err_q  <= 1'b0;
      err_p  <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fe     <= 1'b0;
      ovr    <= 1'b0;
      rie    <= 1'b0;
      eie    <= 1'b0;
      thresh <= 5'd1;
      irq    <= 1'b0;
    end else begin
      stb_q <= rx_stb;
      stb_p <= stb_q;
      err_q <= rx_err;
      err_p <= err_q;
      irq   <= (rie & (5'(count) >= thresh)) | (eie & (fe | ovr));
      if (ctl_wr) begin
        rie    <= din[0];
        eie    <= din[2];
        thresh <= thr_eff;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        fe     <= 1'b0;
        ovr    <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(accept);
        count  <= count + (AW+1)'(accept) - (AW+1)'(pop);
        // Set events override the clear-on-status-read.
        fe     <= err_ev | (fe & ~stat_rd);
        ovr    <= (push_ev & full & ~pop) | (ovr & ~stat_rd);
      end
    end
  end
endmodule
